// File: rtl/ir_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ir_pkg
//  Purpose  : Shared types, constants and frame builders for the AC IR
//             command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD35 = 3'd1,
    ST_WAIT35 = 3'd2,
    ST_GAP    = 3'd3,
    ST_LOAD32 = 3'd4,
    ST_WAIT32 = 3'd5,
    ST_LED    = 3'd6
  } state_t;

  // Key indices into key_in
  localparam int         NUM_KEYS  = 4;
  localparam logic [1:0] KEY_POWER = 2'd0;
  localparam logic [1:0] KEY_MODE  = 2'd1;
  localparam logic [1:0] KEY_UP    = 2'd2;
  localparam logic [1:0] KEY_DOWN  = 2'd3;

  // Setting limits
  localparam logic [2:0] MODE_MAX = 3'd4;
  localparam logic [4:0] TEMP_MIN = 5'd16;
  localparam logic [4:0] TEMP_MAX = 5'd30;
  localparam logic [4:0] TEMP_RST = 5'd26;

  // Frame lengths in bits
  localparam logic [5:0] LEN35 = 6'd35;
  localparam logic [5:0] LEN32 = 6'd32;

  // Settings frame: header above, temperature offset, power, mode
  function automatic logic [34:0] build_frame35(input logic [26:0] hdr,
                                                input logic        pwr,
                                                input logic [2:0]  mode,
                                                input logic [4:0]  temp);
    logic [4:0] toff;
    toff = temp - TEMP_MIN;
    return {hdr, toff[3:0], pwr, mode};
  endfunction

  // Checksum frame: 4-bit checksum above the fixed header, top bits zero
  function automatic logic [34:0] build_frame32(input logic [27:0] hdr,
                                                input logic        pwr,
                                                input logic [2:0]  mode,
                                                input logic [4:0]  temp);
    logic [4:0] toff;
    logic [3:0] cks;
    toff = temp - TEMP_MIN;
    cks  = {1'b0, mode} + toff[3:0] + {3'b000, pwr} + 4'd5;
    return {3'b000, cks, hdr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ir_cmd_sequencer_if
//  Purpose  : Handshake and payload bundle between the command sequencer
//             (master) and the IR encoder (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface ir_cmd_sequencer_if;
  logic        enc_ready;
  logic        enc_done;
  logic        enc_start;
  logic [5:0]  enc_len;
  logic [34:0] enc_data;

  modport master (
    input  enc_ready,
    input  enc_done,
    output enc_start,
    output enc_len,
    output enc_data
  );

  modport slave (
    output enc_ready,
    output enc_done,
    input  enc_start,
    input  enc_len,
    input  enc_data
  );
endinterface
`default_nettype wire

// File: rtl/ir_cmd_sequencer_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Two-flop synchronizer, stability counter and rising-edge
//             event for one raw key line.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYC = 800000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic key_i,
  output logic      event_o
);

  localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          last_q;
  logic          level_q;
  logic          event_q;
  logic [CW-1:0] cnt_q;

  // Synchronize, count equal samples (restart on change, saturate at the
  // limit) and pulse once when a new high level is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
      level_q <= 1'b0;
      event_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      event_q <= 1'b0;
      if (sync2_q != last_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (level_q != last_q) begin
        level_q <= last_q;
        event_q <= last_q;
      end
    end
  end

  assign event_o = event_q;

endmodule
`default_nettype wire

// File: rtl/ir_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ir_cmd_sequencer
//  Purpose  : Debounces remote keys, keeps the AC settings and sequences
//             the IR encoder through a 35-bit frame, a gap and a 32-bit
//             frame, then lights the feedback LED.
//  Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_sequencer
  import ir_pkg::*;
#(
  parameter int          DEBOUNCE_CYC = 800000,
  parameter int          GAP_CYC      = 800000,
  parameter int          LED_CYC      = 4000000,
  parameter logic [26:0] HDR35        = 27'h0000A50,
  parameter logic [27:0] HDR32        = 28'h0000204
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [3:0]      key_in,
  ir_cmd_sequencer_if.master   enc,
  output logic                 busy,
  output logic                 led_out
);

  localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int            LW       = (LED_CYC > 1) ? $clog2(LED_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [LW-1:0] LED_LAST = LW'(LED_CYC - 1);

  logic [NUM_KEYS-1:0] key_evt;
  logic                evt_valid;
  logic [1:0]          evt_idx;

  state_t        state_q,    state_d;
  logic          power_q,    power_d;
  logic [2:0]    mode_q,     mode_d;
  logic [4:0]    temp_q,     temp_d;
  logic          pend_vld_q, pend_vld_d;
  logic [1:0]    pend_idx_q, pend_idx_d;
  logic [GW-1:0] gap_cnt_q,  gap_cnt_d;
  logic [LW-1:0] led_cnt_q,  led_cnt_d;
  logic          start_q,    start_d;
  logic [5:0]    len_q,      len_d;
  logic [34:0]   data_q,     data_d;
  logic          busy_q,     busy_d;
  logic          led_q,      led_d;
  logic          apply_en;
  logic [1:0]    apply_idx;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .key_i   (key_in[gi]),
      .event_o (key_evt[gi])
    );
  end

  // Same-cycle events: the lowest key index wins.
  always_comb begin
    evt_valid = 1'b0;
    evt_idx   = 2'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_evt[i]) begin
        evt_valid = 1'b1;
        evt_idx   = 2'(i);
      end
    end
  end

  // Event arbitration, setting update, sequencing and output next-state.
  always_comb begin
    state_d    = state_q;
    power_d    = power_q;
    mode_d     = mode_q;
    temp_d     = temp_q;
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    gap_cnt_d  = gap_cnt_q;
    led_cnt_d  = led_cnt_q;
    start_d    = 1'b0;
    len_d      = len_q;
    data_d     = data_q;
    apply_en   = 1'b0;
    apply_idx  = 2'd0;

    // A pending event takes the idle slot; a fresh event arriving in that
    // same cycle becomes the new pending one since we are about to go busy.
    if (state_q == ST_IDLE) begin
      if (pend_vld_q) begin
        apply_en   = 1'b1;
        apply_idx  = pend_idx_q;
        pend_vld_d = evt_valid;
        pend_idx_d = evt_idx;
      end else if (evt_valid) begin
        apply_en  = 1'b1;
        apply_idx = evt_idx;
      end
    end else if (evt_valid && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_idx_d = evt_idx;
    end

    if (apply_en) begin
      case (apply_idx)
        KEY_POWER: power_d = ~power_q;
        KEY_MODE:  mode_d  = (mode_q == MODE_MAX) ? 3'd0 : mode_q + 3'd1;
        KEY_UP:    temp_d  = (temp_q >= TEMP_MAX) ? TEMP_MAX : temp_q + 5'd1;
        default:   temp_d  = (temp_q <= TEMP_MIN) ? TEMP_MIN : temp_q - 5'd1;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (apply_en) begin
          state_d = ST_LOAD35;
          len_d   = LEN35;
          data_d  = build_frame35(HDR35, power_d, mode_d, temp_d);
        end
      end
      ST_LOAD35: begin
        if (enc.enc_ready) begin
          start_d = 1'b1;
          state_d = ST_WAIT35;
        end
      end
      ST_WAIT35: begin
        if (enc.enc_done) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_LOAD32;
          len_d   = LEN32;
          data_d  = build_frame32(HDR32, power_q, mode_q, temp_q);
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_LOAD32: begin
        if (enc.enc_ready) begin
          start_d = 1'b1;
          state_d = ST_WAIT32;
        end
      end
      ST_WAIT32: begin
        if (enc.enc_done) begin
          state_d   = ST_LED;
          led_cnt_d = '0;
        end
      end
      ST_LED: begin
        if (led_cnt_q == LED_LAST) begin
          state_d = ST_IDLE;
          len_d   = 6'd0;
          data_d  = '0;
        end else begin
          led_cnt_d = led_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    led_d  = (state_d == ST_LED);
  end

  // State, settings, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      power_q    <= 1'b0;
      mode_q     <= 3'd0;
      temp_q     <= TEMP_RST;
      pend_vld_q <= 1'b0;
      pend_idx_q <= 2'd0;
      gap_cnt_q  <= '0;
      led_cnt_q  <= '0;
      start_q    <= 1'b0;
      len_q      <= 6'd0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      power_q    <= power_d;
      mode_q     <= mode_d;
      temp_q     <= temp_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      led_cnt_q  <= led_cnt_d;
      start_q    <= start_d;
      len_q      <= len_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
    end
  end

  assign enc.enc_start = start_q;
  assign enc.enc_len   = len_q;
  assign enc.enc_data  = data_q;
  assign busy          = busy_q;
  assign led_out       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_cmd_sequencer
//  Purpose  : Directed self-checking bench for ir_cmd_sequencer with a
//             simple encoder model (done 50 cycles after start).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_sequencer;

  localparam int          DEB  = 8;
  localparam int          GAP  = 16;
  localparam int          LEDC = 32;
  localparam logic [26:0] H35  = 27'h0000A50;
  localparam logic [27:0] H32  = 28'h0000204;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic [3:0] key_in = 4'b0000;
  logic       busy;
  logic       led_out;

  ir_cmd_sequencer_if enc_if ();

  ir_cmd_sequencer #(
    .DEBOUNCE_CYC (DEB),
    .GAP_CYC      (GAP),
    .LED_CYC      (LEDC),
    .HDR35        (H35),
    .HDR32        (H32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .enc     (enc_if),
    .busy    (busy),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_starts = 0;
  int          n35 = 0;
  int          n32 = 0;
  int          last_start_cyc = 0;
  int          last_done_cyc = 0;
  int          enc_busy = 0;
  bit          ready_en = 1'b1;
  logic [34:0] log35 [0:63];
  logic [34:0] log32 [0:63];

  // Encoder model: runs 1 time unit after each edge; test tasks run at 2.
  initial begin
    enc_if.enc_ready = 1'b1;
    enc_if.enc_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      enc_if.enc_done = 1'b0;
      if (rst && enc_if.enc_start) begin
        checks++;
        if (enc_if.enc_ready !== 1'b1) begin
          errors++;
          $display("FAIL start_while_not_ready: ready=%b, required 1", enc_if.enc_ready);
        end
        n_starts++;
        last_start_cyc = cyc;
        if (enc_if.enc_len == 6'd35) begin
          log35[n35 % 64] = enc_if.enc_data;
          n35++;
        end else begin
          log32[n32 % 64] = enc_if.enc_data;
          n32++;
        end
        enc_busy         = 50;
        enc_if.enc_ready = 1'b0;
      end else if (enc_busy > 0) begin
        enc_busy--;
        if (enc_busy == 0) begin
          enc_if.enc_done  = 1'b1;
          last_done_cyc    = cyc;
          enc_if.enc_ready = ready_en;
        end
      end else begin
        enc_if.enc_ready = ready_en;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int idx);
    key_in[idx] = 1'b1;
    tick(10);
    key_in[idx] = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int bound, input string name);
    int k;
    k = 0;
    while (n_starts < target && k < bound) begin
      tick(1);
      k++;
    end
    checks++;
    if (n_starts < target) begin
      errors++;
      $display("FAIL %s: starts=%0d, required %0d", name, n_starts, target);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k;
    k = 0;
    while (busy && k < bound) begin
      tick(1);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    checks += 5;
    if (enc_if.enc_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, required 0", enc_if.enc_start); end
    if (enc_if.enc_len !== 6'd0) begin errors++; $display("FAIL reset_len: got %0d, required 0", enc_if.enc_len); end
    if (enc_if.enc_data !== 35'd0) begin errors++; $display("FAIL reset_data: got %h, required 0", enc_if.enc_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led: got %b, required 0", led_out); end
    rst = 1'b1;
    tick(3);
  endtask

  // temp_up from 26: frame 35 low byte B0, 18-cycle done-to-start spacing
  // (1 cycle to enter GAP, 16 gap cycles, 1 cycle in LOAD32), checksum 0.
  task automatic test_single();
    int s0;
    int k;
    int cnt;
    s0 = n_starts;
    press(2);
    wait_starts(s0 + 1, 100, "single_start35");
    checks += 3;
    if (enc_if.enc_len !== 6'd35) begin errors++; $display("FAIL single_len35: got %0d, required 35", enc_if.enc_len); end
    if (log35[(n35 - 1) % 64][7:0] !== 8'hB0) begin errors++; $display("FAIL single_data35: got %h, required b0", log35[(n35 - 1) % 64][7:0]); end
    if (log35[(n35 - 1) % 64][34:8] !== H35) begin errors++; $display("FAIL single_hdr35: got %h, required %h", log35[(n35 - 1) % 64][34:8], H35); end
    wait_starts(s0 + 2, 400, "single_start32");
    checks += 4;
    if (last_start_cyc - last_done_cyc !== GAP + 2) begin errors++; $display("FAIL single_gap: got %0d, required %0d", last_start_cyc - last_done_cyc, GAP + 2); end
    if (enc_if.enc_len !== 6'd32) begin errors++; $display("FAIL single_len32: got %0d, required 32", enc_if.enc_len); end
    if (log32[(n32 - 1) % 64][27:0] !== H32) begin errors++; $display("FAIL single_hdr32: got %h, required %h", log32[(n32 - 1) % 64][27:0], H32); end
    if (log32[(n32 - 1) % 64][34:28] !== 7'h00) begin errors++; $display("FAIL single_cks: got %h, required 0", log32[(n32 - 1) % 64][34:28]); end
    k = 0;
    while (!led_out && k < 200) begin tick(1); k++; end
    cnt = 0;
    while (led_out && cnt < 200) begin cnt++; tick(1); end
    checks += 3;
    if (cnt !== LEDC) begin errors++; $display("FAIL single_led_len: got %0d, required %0d", cnt, LEDC); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b, required 0", busy); end
    if (n_starts !== s0 + 2) begin errors++; $display("FAIL single_start_count: got %0d, required %0d", n_starts, s0 + 2); end
  endtask

  task automatic test_glitch();
    int s0;
    s0 = n_starts;
    key_in[0] = 1'b1;
    tick(5);
    key_in[0] = 1'b0;
    tick(40);
    checks += 2;
    if (n_starts !== s0) begin errors++; $display("FAIL glitch_starts: got %0d, required %0d", n_starts, s0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b, required 0", busy); end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_lo [0:4];
    int s0;
    exp_lo[0] = 8'hB0; exp_lo[1] = 8'hC0; exp_lo[2] = 8'hD0;
    exp_lo[3] = 8'hE0; exp_lo[4] = 8'hE0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s0 = n_starts;
      press(2);
      wait_starts(s0 + 2, 400, "sat_seq");
      wait_idle(200, "sat_idle");
      checks++;
      if (log35[(n35 - 1) % 64][7:0] !== exp_lo[i]) begin
        errors++;
        $display("FAIL sat_frame35[%0d]: got %h, required %h", i, log35[(n35 - 1) % 64][7:0], exp_lo[i]);
      end
    end
    checks++;
    if (log32[(n32 - 1) % 64][31:28] !== 4'h3) begin errors++; $display("FAIL sat_cks: got %h, required 3", log32[(n32 - 1) % 64][31:28]); end
  endtask

  // temp stays 30 (offset 14), power 0: checksum = mode + 19 mod 16.
  task automatic test_mode();
    logic [2:0] exp_mode [0:5];
    logic [3:0] exp_cks  [0:5];
    int s0;
    exp_mode[0] = 3'd1; exp_mode[1] = 3'd2; exp_mode[2] = 3'd3;
    exp_mode[3] = 3'd4; exp_mode[4] = 3'd0; exp_mode[5] = 3'd1;
    exp_cks[0]  = 4'h4; exp_cks[1]  = 4'h5; exp_cks[2]  = 4'h6;
    exp_cks[3]  = 4'h7; exp_cks[4]  = 4'h3; exp_cks[5]  = 4'h4;
    for (int i = 0; i < 6; i++) begin
      s0 = n_starts;
      press(1);
      wait_starts(s0 + 2, 400, "mode_seq");
      wait_idle(200, "mode_idle");
      checks += 3;
      if (log35[(n35 - 1) % 64][2:0] !== exp_mode[i]) begin errors++; $display("FAIL mode_val[%0d]: got %0d, required %0d", i, log35[(n35 - 1) % 64][2:0], exp_mode[i]); end
      if (log32[(n32 - 1) % 64][31:28] !== exp_cks[i]) begin errors++; $display("FAIL mode_cks[%0d]: got %h, required %h", i, log32[(n32 - 1) % 64][31:28], exp_cks[i]); end
      if (n_starts !== s0 + 2) begin errors++; $display("FAIL mode_starts[%0d]: got %0d, required %0d", i, n_starts, s0 + 2); end
    end
  endtask

  // From power 0, mode 1, temp 30: power press runs (E9); temp_down during
  // WAIT35 is kept (power 1, temp 29 -> D9, checksum 4); mode during GAP dropped.
  task automatic test_pending();
    int s0;
    int k;
    s0 = n_starts;
    press(0);
    wait_starts(s0 + 1, 100, "pend_first");
    tick(5);
    press(3);
    k = 0;
    while (!enc_if.enc_done && k < 100) begin tick(1); k++; end
    press(1);
    tick(700);
    checks += 5;
    if (n_starts !== s0 + 4) begin errors++; $display("FAIL pend_starts: got %0d, required %0d", n_starts, s0 + 4); end
    if (log35[(n35 - 2) % 64][7:0] !== 8'hE9) begin errors++; $display("FAIL pend_frame_a: got %h, required e9", log35[(n35 - 2) % 64][7:0]); end
    if (log35[(n35 - 1) % 64][7:0] !== 8'hD9) begin errors++; $display("FAIL pend_frame_b: got %h, required d9", log35[(n35 - 1) % 64][7:0]); end
    if (log32[(n32 - 1) % 64][31:28] !== 4'h4) begin errors++; $display("FAIL pend_cks: got %h, required 4", log32[(n32 - 1) % 64][31:28]); end
    if (busy !== 1'b0) begin errors++; $display("FAIL pend_busy: got %b, required 0", busy); end
  endtask

  // power 1 -> 0, mode 1, temp 29: frame low byte D1.
  task automatic test_ready();
    int s0;
    int k;
    s0 = n_starts;
    ready_en = 1'b0;
    press(0);
    k = 0;
    while (!busy && k < 50) begin tick(1); k++; end
    tick(100);
    checks += 3;
    if (n_starts !== s0) begin errors++; $display("FAIL ready_stall_starts: got %0d, required %0d", n_starts, s0); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ready_stall_busy: got %b, required 1", busy); end
    if (enc_if.enc_start !== 1'b0) begin errors++; $display("FAIL ready_stall_start: got %b, required 0", enc_if.enc_start); end
    ready_en = 1'b1;
    enc_if.enc_ready = 1'b1;
    tick(1);
    checks++;
    if (enc_if.enc_start !== 1'b1) begin errors++; $display("FAIL ready_release_start: got %b, required 1", enc_if.enc_start); end
    wait_starts(s0 + 2, 400, "ready_seq");
    wait_idle(200, "ready_idle");
    checks++;
    if (log35[(n35 - 1) % 64][7:0] !== 8'hD1) begin errors++; $display("FAIL ready_frame: got %h, required d1", log35[(n35 - 1) % 64][7:0]); end
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = n_starts;
    press(0);
    wait_starts(s0 + 2, 400, "rstmid_seq");
    tick(10);
    rst = 1'b0;
    #1;
    checks += 5;
    if (enc_if.enc_start !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b, required 0", enc_if.enc_start); end
    if (enc_if.enc_len !== 6'd0) begin errors++; $display("FAIL rstmid_len: got %0d, required 0", enc_if.enc_len); end
    if (enc_if.enc_data !== 35'd0) begin errors++; $display("FAIL rstmid_data: got %h, required 0", enc_if.enc_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (led_out !== 1'b0) begin errors++; $display("FAIL rstmid_led: got %b, required 0", led_out); end
    tick(3);
    rst = 1'b1;
    tick(300);
    checks += 2;
    if (n_starts !== s0 + 2) begin errors++; $display("FAIL rstmid_no_start: got %0d, required %0d", n_starts, s0 + 2); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b, required 0", busy); end
    press(2);
    wait_starts(s0 + 3, 100, "rstmid_new");
    checks++;
    if (log35[(n35 - 1) % 64][7:0] !== 8'hB0) begin errors++; $display("FAIL rstmid_settings: got %h, required b0", log35[(n35 - 1) % 64][7:0]); end
    wait_idle(400, "rstmid_final_idle");
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_saturate();
    test_mode();
    test_pending();
    test_ready();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_cmd_sequencer.md
Name: ir_cmd_sequencer

Overview:
- Front-end controller for the AC infrared transmitter; runs on the 40 MHz system clock.
- Debounces the remote's keys and maintains the AC setting state (power, mode, temperature).
- On each accepted key, sequences the IR encoder through a two-part command: a 35-bit frame, an inter-frame gap, then a 32-bit frame.
- Drives the feedback LED and arbitrates key events that arrive while a transmission is in progress.

Parameters:
- DEBOUNCE_CYC, 800000: stable cycles required to accept a key level (20 ms at 40 MHz).
- GAP_CYC, 800000: idle cycles between the end of frame 35 and the start of frame 32.
- LED_CYC, 4000000: led_out high time after frame 32 completes (100 ms).
- HDR35, 27'h0000A50: fixed upper bits [34:8] of frame 35.
- HDR32, 28'h0000204: fixed lower bits [27:0] of frame 32.

Ports:
- clk  in  1: system clock, 40 MHz.
- rst  in  1: asynchronous, active-low reset.
- key_in  in  4: raw keys, active-high, asynchronous. [0] power, [1] mode, [2] temp_up, [3] temp_down.
- enc_ready  in  1: encoder idle and able to accept a start.
- enc_done  in  1: one-cycle pulse when the encoder finishes the last bit of a frame.
- enc_start  out  1: one-cycle start pulse to the encoder.
- enc_len  out  6: frame length in bits; 35 or 32.
- enc_data  out  35: frame payload; LSB is sent first; bits above enc_len-1 are 0.
- busy  out  1: high from the first LOAD state until the state machine returns to IDLE.
- led_out  out  1: transmit-complete indicator.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: enc_start=0, enc_len=0, enc_data=0, busy=0, led_out=0.
  - State: FSM=IDLE; power=0, mode=0, temp=26; pending cleared; all counters=0.
  - Reset asserted mid-transfer aborts immediately; no enc_start is issued after release until a new key is accepted.
- Key path, per bit:
  - 2-FF synchronizer, then a debounce counter that resets on any level change.
  - The level is accepted after DEBOUNCE_CYC consecutive equal samples.
  - A 0->1 accepted transition produces a one-cycle event. Glitches shorter than DEBOUNCE_CYC produce no event.
  - Same-cycle events: lowest index wins; the others are dropped.
- Event handling:
  - In IDLE: apply the event to the settings, then go to LOAD35 on the next cycle.
  - In any other state: store the event in a one-deep pending register (first event kept, later ones dropped). It is applied when the FSM returns to IDLE, which takes one extra cycle.
- Setting updates:
  - power: toggles.
  - mode: 0..4 incrementing, 4 wraps to 0.
  - temp_up: saturates at 30.
  - temp_down: saturates at 16.
  - Every accepted event transmits, including saturated ones.
- Frame 35: [2:0]=mode, [3]=power, [7:4]=temp-16, [34:8]=HDR35.
- Frame 32: [27:0]=HDR32, [31:28]=checksum, computed mod 16 as (mode + (temp-16) + power + 5).
- FSM states: IDLE, LOAD35, WAIT35, GAP, LOAD32, WAIT32, LED.
  - LOAD35: drive enc_data and enc_len=35; assert enc_start in the first cycle that enc_ready=1, then go to WAIT35.
  - WAIT35: hold enc_data and enc_len stable; go to GAP on enc_done.
  - GAP: count GAP_CYC cycles, then go to LOAD32.
  - LOAD32 and WAIT32: same as LOAD35 and WAIT35 with frame 32 and enc_len=32; leave WAIT32 on enc_done.
  - LED: led_out=1 for LED_CYC cycles, then IDLE. led_out is registered and is 1 only in the LED state.
  - busy=1 in every state except IDLE.
- Boundary cases:
  - enc_done outside WAIT35 or WAIT32 is ignored.
  - enc_ready low stalls the LOAD state indefinitely.
  - enc_start is never asserted while enc_ready=0.
  - Counter widths are clog2 of their parameter; counters never wrap mid-count.

Decomposition:
- Shared package ir_pkg:
  - FSM state enum.
  - Key index constants.
  - MODE_MAX=4, TEMP_MIN=16, TEMP_MAX=30, TEMP_RST=26.
  - Frame length constants 35 and 32.
- One sub-module, key_debounce: synchronizer, debounce counter and edge detect for one key; instantiated 4 times.

Test Plan (bench uses DEBOUNCE_CYC=8, GAP_CYC=16, LED_CYC=32; the encoder model raises enc_done 50 cycles after enc_start):
- Reset then temp_up held for 10 cycles:
  - One event; temp=27.
  - enc_start with enc_len=35, enc_data[7:0]=8'hB0.
  - Then a 16-cycle gap, then enc_len=32 with checksum 4'h0.
  - led_out high for exactly 32 cycles; busy falls with led_out.
- 5-cycle key pulse -> no event, no enc_start.
- Five temp_up presses from 26:
  - temp saturates at 30; the fifth frame still carries [7:4]=4'hE.
  - Checksum: (0+14+0+5) mod 16 = 4'h3.
- Six mode presses -> mode sequence 1,2,3,4,0,1, one frame each.
- Press during WAIT35, then a second press during GAP:
  - Exactly one extra full sequence follows, applying only the first press.
- enc_ready held low 100 cycles in LOAD35 -> no enc_start; the start pulse follows 1 cycle after enc_ready rises.
- rst pulsed low in WAIT32:
  - All outputs 0 immediately; settings back to power 0, mode 0, temp 26.
  - No further enc_start after release.
